// File: rtl/stump_alu_stage.sv
// Registered Stump ALU stage with NZVC flags and a valid/ready handshake on both sides.
// Defining STUMP_ALU_SKID_EN adds a one-entry skid buffer and makes in_ready a registered output.
module stump_alu_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_A,
  input  logic             shift_c,
  input  logic [WIDTH-1:0] operand_B,
  input  logic [2:0]       func,
  input  logic             cc_en,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       cc
);

  localparam logic [2:0] F_ADC = 3'b001;
  localparam logic [2:0] F_SUB = 3'b010;
  localparam logic [2:0] F_SBC = 3'b011;
  localparam logic [2:0] F_AND = 3'b100;
  localparam logic [2:0] F_OR  = 3'b101;

  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       cc_q, cc_d;
  logic             accept;

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic             cc_write;

  // Signed-overflow rule: operands agree in sign but the sum does not.
  function automatic logic ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r, input logic v, input logic c);
    return {r[WIDTH-1], (r == '0), v, c};
  endfunction

  always_comb begin
    b_eff = (func == F_SUB || func == F_SBC) ? ~operand_B : operand_B;
    case (func)
      F_ADC, F_SBC: cin = cc_q[0];
      F_SUB:        cin = 1'b1;
      default:      cin = 1'b0;
    endcase
    sum = {1'b0, operand_A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    alu_res = sum[WIDTH-1:0];
    alu_c   = sum[WIDTH];
    alu_v   = ovf(operand_A[WIDTH-1], b_eff[WIDTH-1], sum[WIDTH-1]);
    if (func == F_AND) begin
      alu_res = operand_A & operand_B;
      alu_c   = shift_c;
      alu_v   = 1'b0;
    end else if (func == F_OR) begin
      alu_res = operand_A | operand_B;
      alu_c   = shift_c;
      alu_v   = 1'b0;
    end
  end

  // Flags commit at accept time so a following ADC/SBC sees them immediately.
  assign cc_write = accept && cc_en && (func[2:1] != 2'b11);

  always_comb begin
    cc_d = cc_write ? pack_flags(alu_res, alu_v, alu_c) : cc_q;
  end

`ifdef STUMP_ALU_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             consume;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && !skid_valid_q;
  assign consume  = out_valid_q && out_ready;

  always_comb begin
    result_d     = result_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (consume) begin
      if (skid_valid_q) begin
        result_d     = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        result_d = alu_res;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (out_valid_q) begin
        skid_d       = alu_res;
        skid_valid_d = 1'b1;
      end else begin
        result_d    = alu_res;
        out_valid_d = 1'b1;
      end
    end
  end

  // Skid payload needs no reset; its valid bit guards it.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
    if (!rst_n) skid_valid_q <= 1'b0;
    else        skid_valid_q <= skid_valid_d;
  end
`else
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    result_d    = result_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      result_d    = alu_res;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      cc_q        <= 4'b0000;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      cc_q        <= cc_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_stump_alu_stage.sv
// Directed table-driven bench for stump_alu_stage, plus stall and reset sequences.
module tb_stump_alu_stage;

  localparam int WIDTH = 16;
`ifdef STUMP_ALU_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_A;
  logic             shift_c;
  logic [WIDTH-1:0] operand_B;
  logic [2:0]       func;
  logic             cc_en;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       cc;

  int tests = 0;
  int fails = 0;

  stump_alu_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand_A(operand_A), .shift_c(shift_c), .operand_B(operand_B),
    .func(func), .cc_en(cc_en), .result(result), .out_valid(out_valid),
    .out_ready(out_ready), .cc(cc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic        sc;
    logic        en;
    logic [15:0] exp_res;
    logic [3:0]  exp_cc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic sc, input logic en);
    func = f; operand_A = a; operand_B = b; shift_c = sc; cc_en = en;
  endtask

  initial begin
    // {func, A, B, shift_c, cc_en, expected result, expected {N,Z,V,C}}
    vecs[0]  = '{3'b000, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 4'b1010};
    vecs[1]  = '{3'b010, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 4'b1000};
    vecs[2]  = '{3'b011, 16'h0005, 16'h0002, 1'b0, 1'b1, 16'h0002, 4'b0001};
    vecs[3]  = '{3'b100, 16'hF0F0, 16'h0FF0, 1'b1, 1'b1, 16'h00F0, 4'b0001};
    vecs[4]  = '{3'b110, 16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0003, 4'b0001};
    vecs[5]  = '{3'b101, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'b0100};
    vecs[6]  = '{3'b001, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 4'b0101};
    vecs[7]  = '{3'b001, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0003, 4'b0101};
    vecs[8]  = '{3'b111, 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 4'b0101};
    vecs[9]  = '{3'b010, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 4'b0011};
    vecs[10] = '{3'b011, 16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 4'b0101};
    vecs[11] = '{3'b000, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 4'b0101};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(3'b000, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_result", 32'(result), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_cc", 32'(cc), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);

    // Back-to-back accepts with out_ready held high.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].sc, vecs[i].en);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
      check($sformatf("vec%0d_cc", i), 32'(cc), 32'(vecs[i].exp_cc));
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'h1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_out_valid", 32'(out_valid), 32'h0);

    // Back-pressure: D1 = 0x0010+1, then D2 = 0x8000+0x8001 offered for 3 stalled cycles.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    drive(3'b000, 16'h0010, 16'h0001, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("bp_d1_result", 32'(result), 32'h0011);
    check("bp_d1_cc", 32'(cc), 32'h0);
    @(negedge clk);
    check("bp_in_ready_before", 32'(in_ready), SKID ? 32'h1 : 32'h0);
    drive(3'b000, 16'h8000, 16'h8001, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_result", k), 32'(result), 32'h0011);
      check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'h1);
      check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'h0);
      check($sformatf("bp_hold%0d_cc", k), 32'(cc), SKID ? 32'h3 : 32'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = !SKID;
    @(posedge clk); #1;
    check("bp_d2_result", 32'(result), 32'h0001);
    check("bp_d2_valid", 32'(out_valid), 32'h1);
    check("bp_d2_cc", 32'(cc), 32'h3);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_drained", 32'(out_valid), 32'h0);
    check("bp_in_ready_after", 32'(in_ready), 32'h1);

    // Reset during a stall with state in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    drive(3'b000, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(3'b000, 16'h0002, 16'h0002, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("mid_valid", 32'(out_valid), 32'h1);
    check("mid_cc", 32'(cc), 32'h5);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_valid", 32'(out_valid), 32'h0);
    check("rst_mid_cc", 32'(cc), 32'h0);
    check("rst_mid_result", 32'(result), 32'h0);
    check("rst_mid_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_no_stale", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stump_alu_stage.md
Name: stump_alu_stage

Overview:
- Registered ALU stage directly downstream of the Stump shift unit.
- Consumes the shifted operand (shift_out) and the shifter carry (c_out) plus operand B and the ALU function.
- Produces a registered 16-bit result and maintains the NZVC condition-code register.
- Valid/ready handshake on both sides so memory stalls can back-pressure the datapath.

Parameters:
- WIDTH, 16, datapath width; only 16 is supported for Stump, and the parameter exists for bench scaling.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  operands and function valid this cycle.
- in_ready  output  1  stage can accept an operation this cycle.
- operand_A  input  WIDTH  shifted operand, from shifter shift_out.
- shift_c  input  1  shifter carry, from shifter c_out.
- operand_B  input  WIDTH  second operand (register or immediate).
- func  input  3  000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR, 110 ADDR (add, no CC), 111 BADD (add, no CC).
- cc_en  input  1  update NZVC on this operation (ignored for func 11x).
- result  output  WIDTH  registered ALU result.
- out_valid  output  1  result holds an unconsumed operation.
- out_ready  input  1  downstream consumes result this cycle.
- cc  output  4  registered flags {N,Z,V,C}.

Behaviour:
- Reset (rst_n low at a clock edge), regardless of in-flight state:
  - result = 0, out_valid = 0, cc = 4'b0000; any skid entry is discarded.
  - in_ready = 1 in the first cycle after reset is released.
- Accept: transfer when in_valid && in_ready at a clock edge.
  - Output register loads the computed result.
  - out_valid = 1 on the next cycle. Latency is 1 clock from accept to out_valid.
- Consume: out_valid && out_ready at a clock edge clears out_valid, unless a new accept loads the same edge.
- Simultaneous consume and accept: result is replaced, out_valid stays 1, and no bubble is inserted.
- Base in_ready = !out_valid || out_ready (combinational path from out_ready).
- Held output: while out_valid && !out_ready, result and out_valid are held stable.
- Arithmetic is WIDTH+1-bit unsigned:
  - ADD: A+B+0.
  - ADC: A+B+cc.C.
  - SUB: A+~B+1.
  - SBC: A+~B+cc.C.
  - C = bit WIDTH of the sum (SUB C=1 means no borrow).
  - V = (A[15]==B'[15]) && (sum[15]!=A[15]), where B' is the inverted B for SUB/SBC.
- Logic (AND, OR): C = shift_c, V = 0.
- N = result[15]; Z = (result == 0).
- CC update: written on the accept edge when cc_en && func[2:1] != 2'b11; otherwise held.
- ADC/SBC carry source: use the current cc register value. Back-to-back accepts therefore see the flags written by the previous accept with no hazard, because cc updates at accept, not at consume.
- cc changes only on accepted operations; stalls never modify cc.
- in_valid low: no state change except a consume.

Optional Feature:
- Macro STUMP_ALU_SKID_EN.
- When defined:
  - Adds one skid entry (result plus valid); in_ready becomes a pure register output, equal to !skid_valid.
  - When out_valid && !out_ready and an accept occurs, the new result goes to the skid entry.
  - When the output is consumed, the skid entry moves to the output register on the same edge.
  - Ordering is strictly FIFO.
  - Maximum occupancy is 2; in_ready = 0 only when the skid entry is full.
  - cc still updates at accept time.
- When undefined: single output register and the combinational in_ready defined above.

Test Plan:
- Reset then idle: rst_n low 2 cycles → result=0, out_valid=0, cc=0000, in_ready=1.
- ADD with cc_en=1: A=16'h7FFF, B=16'h0001 → next cycle result=16'h8000, cc={N1,Z0,V1,C0}.
- Back-to-back SUB then SBC:
  - SUB A=16'h0000, B=16'h0001 → result=16'hFFFF, C=0.
  - SBC A=16'h0005, B=16'h0002 on the next cycle → result=16'h0002 (uses C=0).
- AND with shift_c=1, cc_en=1: A=16'hF0F0, B=16'h0FF0 → result=16'h00F0, cc=0001.
  - Then ADDR with cc_en=1 → cc unchanged.
- Back-pressure: hold out_ready=0 with in_valid=1 for 3 cycles → result stable.
  - Base build: in_ready=0.
  - SKID build: exactly one extra accept, then in_ready=0.
  - Release out_ready: results emerge in issue order.
- Reset mid-stall: out_valid=1, out_ready=0 (skid full if enabled), assert rst_n=0 one edge → out_valid=0, cc=0000, in_ready=1 after release.
